// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns and scan FSM states for the 7-segment scan controller
package seg_pkg;
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_BLANK
    } scan_state_t;
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: BCD nibble to {dp,g..a} pattern with dp clear; codes 10-15 are blank
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);
    always_comb begin
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multiplexed 7-segment scanner with blanking gaps and
// frame-synchronous double-buffered digit data
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DRIVE_END = CW'(REFRESH_DIV - BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    scan_state_t             r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [4*NUM_DIGITS-1:0] r_pd_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_pd_dp;
    logic                    r_sh_lzb;
    logic                    r_pd_lzb;
    logic                    r_pend_valid;

    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic [3:0]              w_nibble;
    logic [7:0]              w_dec;
    logic [7:0]              w_seg;
    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_apply;

    assign w_slot_end = r_cnt == CNT_LAST;
    assign w_wrap     = w_slot_end && r_idx == IDX_LAST;
    // shadow frame only changes when a frame starts: at the wrap or when leaving IDLE
    assign w_apply    = enable && (r_state == ST_IDLE || w_wrap);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
        assign w_lz_blank[k] = r_sh_lzb && k != 0 && (r_sh_digits >> (4*k)) == '0;
    end

    assign w_nibble = r_sh_digits[4*r_idx +: 4];

    bcd_seg_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

    assign w_seg = w_lz_blank[r_idx] ? SEG_BLANK : w_dec | {r_sh_dp[r_idx], 7'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_sh_digits  <= '1;
            r_sh_dp      <= '0;
            r_sh_lzb     <= 1'b0;
            r_pd_digits  <= '0;
            r_pd_dp      <= '0;
            r_pd_lzb     <= 1'b0;
            r_pend_valid <= 1'b0;
            seg_out      <= SEG_BLANK;
            an_out       <= '0;
            frame_done   <= 1'b0;
        end else begin
            if (load) begin
                r_pd_digits <= digits_in;
                r_pd_dp     <= dp_in;
                r_pd_lzb    <= lzb_in;
            end
            r_pend_valid <= w_apply ? 1'b0 : r_pend_valid || load;
            if (w_apply && (load || r_pend_valid)) begin
                r_sh_digits <= load ? digits_in : r_pd_digits;
                r_sh_dp     <= load ? dp_in : r_pd_dp;
                r_sh_lzb    <= load ? lzb_in : r_pd_lzb;
            end
            if (!enable || r_state == ST_IDLE) begin
                r_state    <= enable ? ST_DRIVE : ST_IDLE;
                r_cnt      <= '0;
                r_idx      <= '0;
                seg_out    <= SEG_BLANK;
                an_out     <= '0;
                frame_done <= 1'b0;
            end else begin
                r_cnt      <= w_slot_end ? '0 : r_cnt + 1'b1;
                r_idx      <= w_wrap ? '0 : w_slot_end ? r_idx + 1'b1 : r_idx;
                r_state    <= (w_slot_end || r_cnt + 1'b1 < DRIVE_END) ? ST_DRIVE : ST_BLANK;
                seg_out    <= r_state == ST_DRIVE ? w_seg : SEG_BLANK;
                an_out     <= r_state == ST_DRIVE ? NUM_DIGITS'(1) << r_idx : '0;
                frame_done <= w_wrap;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: scoreboard bench with a frame-position reference model
module tb_seven_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic        lzb_in = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lzb_in     (lzb_in),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // reference model: the frame is a sequence of FRAME positions, each digit owning DIV of them
    localparam logic [7:0] TABLE [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int          pos = 0;
    bit          run = 0;
    bit          pv = 0;
    logic [15:0] sh_d = '1;
    logic [15:0] pd_d = '0;
    logic [3:0]  sh_dp = '0;
    logic [3:0]  pd_dp = '0;
    logic        sh_lzb = 1'b0;
    logic        pd_lzb = 1'b0;

    function automatic logic [7:0] ref_seg(input int k);
        logic [3:0] nib;
        nib = sh_d[4*k +: 4];
        if (sh_lzb && k > 0 && (sh_d >> (4*k)) == 16'd0) return 8'h00;
        return (nib < 4'd10 ? TABLE[nib] : 8'h00) | (sh_dp[k] ? 8'h80 : 8'h00);
    endfunction

    initial forever begin
        exp_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            run = 0; pos = 0; pv = 0;
            sh_d = '1; sh_dp = '0; sh_lzb = 1'b0;
            q.delete();
        end else begin
            e = '0;
            if (enable && run) begin
                if (pos % DIV < DIV - BLK) begin
                    e.an  = 4'(1 << (pos / DIV));
                    e.seg = ref_seg(pos / DIV);
                end
                e.fd = pos == FRAME - 1;
            end
            if (enable && (!run || pos == FRAME - 1)) begin
                if (load) {sh_d, sh_dp, sh_lzb} = {digits_in, dp_in, lzb_in};
                else if (pv) {sh_d, sh_dp, sh_lzb} = {pd_d, pd_dp, pd_lzb};
                pv = 0;
            end else if (load) begin
                {pd_d, pd_dp, pd_lzb} = {digits_in, dp_in, lzb_in};
                pv = 1;
            end
            pos = (enable && run) ? (pos + 1) % FRAME : 0;
            run = enable;
            q.push_back(e);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) cur = '0;
        else if (q.size() > 0) cur = q.pop_front();
        check("sb_seg", seg_out, cur.seg);
        check("sb_an", an_out, cur.an);
        check("sb_fd", frame_done, cur.fd);
        check("an_onehot0", $onehot0(an_out), 1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        digits_in = d;
        dp_in     = dp;
        lzb_in    = lz;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic wait_fd();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (frame_done !== 1'b1 && i < 4 * FRAME);
        check("fd_seen", frame_done, 1);
    endtask

    // starts at the negedge of the frame_done cycle; segs packs {d3,d2,d1,d0}
    task automatic check_frame(input string name, input logic [31:0] segs);
        for (int k = 0; k < N; k++) begin
            repeat (k == 0 ? 1 : 2) @(negedge clk);
            check({name, "_an"}, an_out, 32'(1 << k));
            check({name, "_seg"}, seg_out, 32'(segs[8*k +: 8]));
            repeat (DIV - BLK) @(negedge clk);
            check({name, "_blank"}, an_out, 0);
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int k = 0; k < N; k++) d[4*k +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", seg_out, 0);
        check("reset_an", an_out, 0);
        check("reset_fd", frame_done, 0);
        #1 rst_n = 1'b1;
        tick(13);
        check("pre_reset_an", an_out, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("async_reset_an", an_out, 0);
        check("async_reset_seg", seg_out, 0);
        tick(2);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("first_slot_an", an_out, 4'b0001);
        check("first_slot_seg", seg_out, 8'h00);

        do_load(16'h1234, 4'b0100, 1'b0);
        wait_fd();
        check_frame("f1234", 32'h06DB4F66);
        wait_fd();
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (frame_done !== 1'b1 && c < 100);
        check("fd_period", c, FRAME);

        do_load(16'h0075, 4'b0000, 1'b1);
        wait_fd();
        check_frame("lzb0075", 32'h0000076D);
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_fd();
        check_frame("lzb0000", 32'h0000003F);
        do_load(16'h0005, 4'b1111, 1'b1);
        wait_fd();
        check_frame("lzb_dp", 32'h000000ED);

        wait_fd();
        do_load(16'h1111, 4'b0000, 1'b0);
        tick(3);
        do_load(16'h2222, 4'b0000, 1'b0);
        wait_fd();
        check_frame("last_wins", 32'h5B5B5B5B);
        do_load(16'h3333, 4'b0000, 1'b0);
        wait_fd();
        check_frame("wrap_load", 32'h4F4F4F4F);

        wait_fd();
        repeat (2 * DIV + 3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_an", an_out, 0);
        check("disable_fd", frame_done, 0);
        do_load(16'h9999, 4'b0000, 1'b0);
        tick(3);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("reenable_an", an_out, 4'b0001);
        check("reenable_seg", seg_out, 8'h6F);

        do_load(16'hABCD, 4'b1111, 1'b0);
        wait_fd();
        check_frame("hex_dp", 32'h80808080);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) do_load(rand_digits(), 4'($urandom), 1'($urandom));
            else tick();
            if ($urandom_range(0, 299) == 0) enable = ~enable;
        end
        enable = 1'b1;
        for (int i = 0; i < 1000 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) do_load(rand_digits(), 4'($urandom), 1'($urandom));
            else tick();
        end
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
